// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} serial_adder_state_t;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells: a half adder, and a full adder composed of two of them.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder u_ha0 (.a(a),    .b(b),   .s(w_s0), .c(w_c0));
   half_adder u_ha1 (.a(w_s0), .b(cin), .s(s),    .c(w_c1));

   assign cout = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one shared full-adder cell walks the operands LSB-first.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   serial_adder_state_t r_state;
   serial_adder_state_t w_state_next;

   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum_sr;
   logic [WIDTH-1:0] w_sum_shifted;
   logic [CW-1:0]    r_count;
   logic             r_carry;
   logic             r_in_ready;
   logic             w_load;
   logic             w_s;
   logic             w_cout;

   full_adder u_fa (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   // New sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sum_shifted = w_s;
      end else begin : g_wn
         assign w_sum_shifted = {w_s, r_sum_sr[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid && r_in_ready) begin
               w_load       = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (r_count == LAST_BIT) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // in_ready is a flop so it stays low through reset and rises one edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
      end else if (w_load) begin
         r_a_sr  <= a;
         r_b_sr  <= b;
         r_carry <= 1'b0;
         r_count <= '0;
      end else if (r_state == SHIFT) begin
         r_a_sr   <= r_a_sr >> 1;
         r_b_sr   <= r_b_sr >> 1;
         r_sum_sr <= w_sum_shifted;
         r_carry  <= w_cout;
         r_count  <= r_count + CW'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum_sr;
   assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with an 8-bit and a 1-bit instance.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         n_assert = 0;
   int         n_fail = 0;

   logic       iv8, ir8, ov8, or8, co8;
   logic [7:0] a8, b8, s8;
   logic       iv1, ir1, ov1, or1, co1;
   logic [0:0] a1, b1, s1;

   logic       sel;
   logic       cur_ir, cur_ov, cur_co;
   logic [7:0] cur_sum;

   assign cur_ir  = sel ? ir1 : ir8;
   assign cur_ov  = sel ? ov1 : ov8;
   assign cur_co  = sel ? co1 : co8;
   assign cur_sum = sel ? {7'b0, s1} : s8;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .sum(s8), .carry_out(co8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready;
      int n;
      n = 0;
      while (!cur_ir && n < 50) begin
         step();
         n++;
      end
   endtask

   // Returns the number of edges from the input handshake until out_valid is seen.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!cur_ov && lat < 50) begin
         step();
         lat++;
      end
   endtask

   task automatic do_op(input logic s, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [7:0] es, input logic ec, input int elat);
      int lat;
      sel = s;
      if (s) begin
         a1 = opa[0]; b1 = opb[0]; iv1 = 1'b1;
      end else begin
         a8 = opa; b8 = opb; iv8 = 1'b1;
      end
      wait_ready();
      step();
      iv1 = 1'b0;
      iv8 = 1'b0;
      wait_done(lat);
      check("latency", lat, elat);
      check("sum", cur_sum, es);
      check("carry_out", cur_co, ec);
      check("in_ready_busy", cur_ir, 1'b0);
      $display("op w=%0d a=%0d b=%0d -> sum=%0d carry=%0d lat=%0d",
               s ? 1 : 8, opa, opb, cur_sum, cur_co, lat);
   endtask

   initial begin
      int lat, hs, prev_hs;
      logic [7:0] ra, rb;
      logic [8:0] full;

      sel = 1'b0;
      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
      iv1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b1;

      // Reset state
      repeat (3) step();
      check("rst_in_ready", ir8, 1'b0);
      check("rst_out_valid", ov8, 1'b0);
      check("rst_sum", s8, 8'd0);
      check("rst_carry", co8, 1'b0);
      rst_n = 1'b1;
      check("in_ready_before_edge", ir8, 1'b0);
      step();
      check("in_ready_after_release", ir8, 1'b1);
      check("in_ready_w1_after_release", ir1, 1'b1);

      // Basic sums
      do_op(1'b0, 8'd3,   8'd5,   8'd8,   1'b0, 8);
      do_op(1'b0, 8'd255, 8'd1,   8'd0,   1'b1, 8);
      do_op(1'b0, 8'd255, 8'd255, 8'd254, 1'b1, 8);

      // Backpressure
      step();
      or8 = 1'b0;
      a8 = 8'd10; b8 = 8'd20; iv8 = 1'b1;
      wait_ready();
      step();
      iv8 = 1'b0;
      wait_done(lat);
      check("bp_latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
         iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
         step();
         check("bp_sum", s8, 8'd30);
         check("bp_carry", co8, 1'b0);
         check("bp_in_ready", ir8, 1'b0);
         check("bp_out_valid", ov8, 1'b1);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      step();
      check("bp_release_out_valid", ov8, 1'b0);
      check("bp_release_in_ready", ir8, 1'b1);
      step();
      check("bp_idle_out_valid", ov8, 1'b0);
      check("bp_idle_in_ready", ir8, 1'b1);
      $display("op w=8 a=10 b=20 backpressured 5 cycles -> sum=30");

      // Reset in the third SHIFT cycle
      a8 = 8'd100; b8 = 8'd27; iv8 = 1'b1;
      wait_ready();
      step();
      iv8 = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", ir8, 1'b0);
      check("mid_rst_out_valid", ov8, 1'b0);
      check("mid_rst_sum", s8, 8'd0);
      check("mid_rst_carry", co8, 1'b0);
      repeat (2) step();
      check("held_rst_in_ready", ir8, 1'b0);
      check("held_rst_out_valid", ov8, 1'b0);
      check("held_rst_sum", s8, 8'd0);
      rst_n = 1'b1;
      check("release_in_ready_low", ir8, 1'b0);
      step();
      check("release_in_ready_high", ir8, 1'b1);
      do_op(1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 8);

      // WIDTH=1 instance
      do_op(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1);
      do_op(1'b1, 8'd1, 8'd0, 8'd1, 1'b0, 1);

      // Back-to-back with in_valid held high
      sel = 1'b0;
      or8 = 1'b1;
      iv8 = 1'b1;
      prev_hs = 0;
      for (int i = 0; i < 20; i++) begin
         wait_ready();
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         a8 = ra; b8 = rb;
         step();
         hs = cyc;
         wait_done(lat);
         full = {1'b0, ra} + {1'b0, rb};
         check("b2b_sum", s8, full[7:0]);
         check("b2b_carry", co8, full[8]);
         if (i > 0) check("b2b_spacing", hs - prev_hs, 10);
         prev_hs = hs;
         $display("op w=8 a=%0d b=%0d -> sum=%0d carry=%0d", ra, rb, s8, co8);
      end
      iv8 = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
